// File: rtl/master_out_port.sv
// Serial bus master port: accepts one client request at a time and shifts
// it onto the bus LSB first. The address frame is 12 bits, with 8 data bits
// alongside it. Each extra write-burst beat is sent as an 8-bit data frame.
module master_out_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_address,
    input  logic [7:0]  req_data,
    input  logic [12:0] req_burst,
    input  logic        wdata_valid,
    input  logic [7:0]  wdata,
    output logic        wdata_ready,
    input  logic        slave_ready,
    output logic        master_valid,
    output logic        tx_address,
    output logic        tx_data,
    output logic        read_en,
    output logic        write_en,
    output logic [12:0] burst,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR_SHIFT,
        BEAT_WAIT,
        BEAT_REQ,
        BEAT_SHIFT
    } state_t;

    localparam logic [3:0] ADDR_LAST_BIT = 4'd11;
    localparam logic [3:0] DATA_LAST_BIT = 4'd7;

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_addr;
    logic [7:0]  r_data;
    logic [12:0] r_burst;
    logic [11:0] r_beat_cnt;
    logic [3:0]  r_bit_cnt;
    logic        r_read_en;
    logic        r_write_en;
    logic        r_done;
    logic        w_enter_idle;

    // State register; reset aborts any transfer in flight.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode and bus-facing outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        master_valid = 1'b0;
        wdata_ready  = 1'b0;
        tx_address   = 1'b0;
        tx_data      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) w_next_state = REQ;
            end
            REQ: begin
                master_valid = 1'b1;
                tx_address   = r_addr[0];
                tx_data      = r_write_en & r_data[0];
                if (slave_ready) w_next_state = ADDR_SHIFT;
            end
            ADDR_SHIFT: begin
                tx_address = r_addr[0];
                tx_data    = (r_write_en && r_bit_cnt <= DATA_LAST_BIT) ? r_data[0] : 1'b0;
                if (r_bit_cnt == ADDR_LAST_BIT) begin
                    // Read bursts need no further frames: the slave walks the addresses.
                    if (r_beat_cnt == 12'd0 || !r_write_en) w_next_state = IDLE;
                    else                                     w_next_state = BEAT_WAIT;
                end
            end
            BEAT_WAIT: begin
                wdata_ready = 1'b1;
                if (wdata_valid) w_next_state = BEAT_REQ;
            end
            BEAT_REQ: begin
                master_valid = 1'b1;
                tx_data      = r_data[0];
                if (slave_ready) w_next_state = BEAT_SHIFT;
            end
            BEAT_SHIFT: begin
                tx_data = r_data[0];
                if (r_bit_cnt == DATA_LAST_BIT) begin
                    if (r_beat_cnt == 12'd0) w_next_state = IDLE;
                    else                     w_next_state = BEAT_WAIT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_enter_idle = (r_state != IDLE) && (w_next_state == IDLE);

    // Capture the request, shift frames out, and count bits and beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_bit_cnt  <= '0;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_enter_idle;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_address;
                        r_data     <= req_data;
                        r_burst    <= req_burst;
                        r_write_en <= req_write;
                        r_read_en  <= ~req_write;
                        r_beat_cnt <= req_burst[0] ? req_burst[12:1] : 12'd0;
                        r_bit_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (slave_ready) begin
                        r_addr    <= {1'b0, r_addr[11:1]};
                        r_data    <= {1'b0, r_data[7:1]};
                        r_bit_cnt <= 4'd1;
                    end
                end
                ADDR_SHIFT: begin
                    r_addr <= {1'b0, r_addr[11:1]};
                    r_data <= {1'b0, r_data[7:1]};
                    if (r_bit_cnt < ADDR_LAST_BIT) r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                BEAT_WAIT: begin
                    if (wdata_valid) begin
                        r_data <= wdata;
                        if (r_beat_cnt != 12'd0) r_beat_cnt <= r_beat_cnt - 12'd1;
                    end
                end
                BEAT_REQ: begin
                    if (slave_ready) begin
                        r_data    <= {1'b0, r_data[7:1]};
                        r_bit_cnt <= 4'd1;
                    end
                end
                BEAT_SHIFT: begin
                    r_data <= {1'b0, r_data[7:1]};
                    if (r_bit_cnt < DATA_LAST_BIT) r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                default: ;
            endcase
            // Transfer type is only meaningful while a transaction is open.
            if (w_enter_idle) begin
                r_read_en  <= 1'b0;
                r_write_en <= 1'b0;
            end
        end
    end

    // While reset is held the port must not advertise readiness.
    assign req_ready = (r_state == IDLE) && !reset;
    assign busy      = (r_state != IDLE);
    assign read_en   = r_read_en;
    assign write_en  = r_write_en;
    assign burst     = r_burst;
    assign done      = r_done;

endmodule

// File: tb/tb_master_out_port.sv
// Self-checking bench for master_out_port. A bus-level monitor rebuilds each
// serial frame from the tx lines and compares it with the request issued.
module tb_master_out_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_address;
    logic [7:0]  req_data;
    logic [12:0] req_burst;
    logic        wdata_valid;
    logic [7:0]  wdata;
    logic        wdata_ready;
    logic        slave_ready;
    logic        master_valid;
    logic        tx_address;
    logic        tx_data;
    logic        read_en;
    logic        write_en;
    logic [12:0] burst;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] beat_vals[$];

    always #5 clk = ~clk;

    master_out_port dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data), .req_burst(req_burst),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .slave_ready(slave_ready), .master_valid(master_valid),
        .tx_address(tx_address), .tx_data(tx_data),
        .read_en(read_en), .write_en(write_en), .burst(burst),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it on the bus until done.
    // delay >= 0: slave holds slave_ready low for that many master_valid cycles;
    // delay < 0: a fresh random wait of 0..3 cycles per frame.
    task automatic run_txn(input string name, input logic wr, input logic [11:0] addr,
                           input logic [7:0] data, input logic [12:0] bst, input int delay);
        int          exp_frames;
        int          frames;
        int          frame_left;
        int          frame_idx;
        int          mv_run;
        int          first_mv;
        int          slave_delay;
        int          wd_wait;
        int          wd_delay;
        int          beat_i;
        int          last_end;
        int          done_cyc;
        int          bad_lines;
        int          bad_type;
        int          bad_mv;
        int          n_beats;
        logic [11:0] fa;
        logic [11:0] fd;
        logic [7:0]  exp_beat;

        n_beats     = (wr && bst[0]) ? int'(bst[12:1]) : 0;
        exp_frames  = 1 + n_beats;
        frames      = 0;
        frame_left  = 0;
        frame_idx   = 0;
        mv_run      = 0;
        first_mv    = -1;
        slave_delay = (delay >= 0) ? delay : int'($urandom_range(0, 3));
        wd_wait     = 0;
        wd_delay    = int'($urandom_range(0, 2));
        beat_i      = 0;
        last_end    = -100;
        done_cyc    = -1;
        bad_lines   = 0;
        bad_type    = 0;
        bad_mv      = 0;
        fa          = '0;
        fd          = '0;

        check({name, ".ready"}, req_ready, 1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = addr;
        req_data    = data;
        req_burst   = bst;
        step();
        req_valid = 1'b0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                check({name, ".done_idle"}, {busy, req_ready}, 2'b01);
                break;
            end
            // Changed request fields must not disturb the transfer in flight.
            req_write   = 1'($urandom);
            req_address = 12'($urandom);
            req_data    = 8'($urandom);
            req_burst   = 13'($urandom);
            req_valid   = busy && ($urandom_range(0, 3) == 0);
            if (busy && (read_en !== !wr || write_en !== wr || burst !== bst)) bad_type++;
            if (wdata_ready && !wr) bad_type++;
            if (frame_left > 0 && master_valid) bad_mv++;

            if (master_valid) begin
                slave_ready = (mv_run == slave_delay);
                mv_run++;
            end else begin
                slave_ready = 1'($urandom);
            end

            if (frame_left > 0) begin
                fa[frame_idx] = tx_address;
                fd[frame_idx] = tx_data;
                frame_idx++;
                frame_left--;
            end else if (master_valid && slave_ready) begin
                if (first_mv < 0) first_mv = mv_run;
                if (mv_run != slave_delay + 1) bad_mv++;
                mv_run      = 0;
                slave_delay = (delay >= 0) ? delay : int'($urandom_range(0, 3));
                fa          = '0;
                fd          = '0;
                fa[0]       = tx_address;
                fd[0]       = tx_data;
                frame_idx   = 1;
                frame_left  = (frames == 0) ? 11 : 7;
            end else if (!master_valid && (tx_address !== 1'b0 || tx_data !== 1'b0)) begin
                bad_lines++;
            end

            if (frame_idx > 0 && frame_left == 0) begin
                if (frames == 0) begin
                    check({name, ".addr"}, fa, addr);
                    check({name, ".data0"}, fd, wr ? {4'h0, data} : 12'h000);
                end else begin
                    exp_beat = (frames - 1 < beat_vals.size()) ? beat_vals[frames - 1] : 8'h00;
                    check({name, ".beat_data"}, fd, {4'h0, exp_beat});
                    check({name, ".beat_addr"}, fa, 12'h000);
                end
                frames++;
                last_end  = cyc;
                frame_idx = 0;
            end

            if (wdata_ready) begin
                if (wd_wait >= wd_delay) begin
                    wdata_valid = 1'b1;
                    wdata       = (beat_i < beat_vals.size()) ? beat_vals[beat_i] : 8'h00;
                    beat_i++;
                    wd_wait     = 0;
                    wd_delay    = int'($urandom_range(0, 2));
                end else begin
                    wdata_valid = 1'b0;
                    wdata       = 8'($urandom);
                    wd_wait++;
                end
            end else begin
                wdata_valid = 1'($urandom);
                wdata       = 8'($urandom);
            end
            step();
        end

        req_valid   = 1'b0;
        slave_ready = 1'b0;
        wdata_valid = 1'b0;
        check({name, ".finished"}, (done_cyc >= 0), 1);
        check({name, ".frames"}, frames, exp_frames);
        check({name, ".done_timing"}, done_cyc, last_end + 1);
        check({name, ".beats_taken"}, beat_i, n_beats);
        check({name, ".idle_lines"}, bad_lines, 0);
        check({name, ".type_burst"}, bad_type, 0);
        check({name, ".mv_handshake"}, bad_mv, 0);
        if (delay >= 0) check({name, ".mv_hold"}, first_mv, delay + 1);
        step();
        check({name, ".done_pulse"}, {done, busy}, 2'b00);
        step();
        check({name, ".no_second_txn"}, busy, 0);
    endtask

    initial begin
        logic [11:0] r_addr_sel;
        logic [12:0] r_bst;
        logic        r_wr;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_data    = '0;
        req_burst   = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        slave_ready = 1'b0;
        #1;
        check("reset.outputs",
              {master_valid, tx_address, tx_data, read_en, write_en, busy, done, wdata_ready, req_ready},
              9'h000);
        check("reset.burst", burst, 13'h0000);
        step();
        step();
        reset = 1'b0;
        step();
        check("release.ready_busy", {req_ready, busy, done}, 3'b100);

        // Single read, slave always ready.
        run_txn("t034_read", 1'b0, 12'hA5C, 8'h5A, 13'd0, 0);
        // Single write with a slave that stalls the request three cycles.
        run_txn("t035_write", 1'b1, 12'h001, 8'h96, 13'd0, 3);
        // Write burst with two extra beats.
        beat_vals = '{8'h11, 8'h22};
        run_txn("t036_wburst", 1'b1, 12'h3C7, 8'h96, 13'b0000000000101, -1);
        // Read burst: one address frame only.
        beat_vals = {};
        run_txn("t037_rburst", 1'b0, 12'h7E1, 8'hFF, 13'd7, 1);

        // Reset in the middle of the address frame, at bit 5.
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 12'h3A5;
        req_data    = 8'hFF;
        req_burst   = 13'd3;
        slave_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("t038.handshake", master_valid, 1);
        for (int k = 0; k < 5; k++) step();
        r_addr_sel = 12'h3A5;
        check("t038.bit5_lines", {tx_address, tx_data}, {r_addr_sel[5], 1'b1});
        #2;
        reset = 1'b1;
        #1;
        check("t038.abort_outputs",
              {master_valid, tx_address, tx_data, read_en, write_en, busy, done, wdata_ready, req_ready},
              9'h000);
        check("t038.abort_burst", burst, 13'h0000);
        step();
        step();
        check("t038.no_done", done, 0);
        reset       = 1'b0;
        slave_ready = 1'b0;
        step();
        check("t038.release", {req_ready, busy, done}, 3'b100);
        beat_vals = '{8'hC3};
        run_txn("t038_after", 1'b1, 12'h5A6, 8'h3C, 13'b0000000000011, -1);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            r_wr      = 1'($urandom);
            r_bst     = {12'($urandom_range(0, 3)), 1'($urandom)};
            beat_vals = {};
            if (r_wr && r_bst[0]) begin
                for (int b = 0; b < int'(r_bst[12:1]); b++) beat_vals.push_back(8'($urandom));
            end
            run_txn($sformatf("rand%0d", t), r_wr, 12'($urandom), 8'($urandom), r_bst, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/master_out_port.md
MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clock clk.
REQ-003 req_valid  input  1  client request present.
REQ-004 req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-005 req_write  input  1  1 = write, 0 = read; captured at acceptance.
REQ-006 req_address  input  12  start address; captured at acceptance.
REQ-007 req_data  input  8  first write beat; captured at acceptance.
REQ-008 req_burst  input  13  bit0 = burst enable, [12:1] = extra beats; captured at acceptance.
REQ-009 wdata_valid / wdata  input  1 / 8  next write-burst beat from client.
REQ-010 wdata_ready  output  1  high only in BEAT_WAIT.
REQ-011 slave_ready  input  1  from bus slave port.
REQ-012 master_valid  output  1  bus request; handshake = master_valid & slave_ready.
REQ-013 tx_address / tx_data  output  1 / 1  serial address and data lines, LSB first.
REQ-014 read_en / write_en  output  1 / 1  transfer type; held stable from acceptance to return to IDLE.
REQ-015 burst  output  13  registered copy of req_burst; held stable for whole transaction.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle pulse on the cycle the FSM enters IDLE from a transfer.

Function
REQ-018 FSM states SHALL be IDLE, REQ, ADDR_SHIFT, BEAT_WAIT, BEAT_REQ, BEAT_SHIFT.
REQ-019 IDLE: on req_valid, capture address/data/type/burst into shift registers, beat counter = burst[0] ? burst[12:1] : 0, go to REQ.
REQ-020 REQ: master_valid = 1, tx_address = addr[0], tx_data = write ? data[0] : 0; hold until slave_ready = 1 (handshake cycle).
REQ-021 Handshake cycle SHALL carry bit 0; bit counter reset to 1, go to ADDR_SHIFT; master_valid = 0 from next cycle.
REQ-022 ADDR_SHIFT: drive addr[k] and (write and k<=7 ? data[k] : 0) on cycle k after handshake, k = 1..11; total address window 12 cycles.
REQ-023 After bit 11: beat counter 0 -> IDLE with done; beat counter > 0 and write -> BEAT_WAIT; beat counter > 0 and read -> IDLE with done (slave generates read burst addresses).
REQ-024 BEAT_WAIT: wdata_ready = 1; on wdata_valid load wdata, decrement beat counter, go to BEAT_REQ.
REQ-025 BEAT_REQ: master_valid = 1, tx_data = data[0], tx_address = 0; on slave_ready go to BEAT_SHIFT with bit counter 1.
REQ-026 BEAT_SHIFT: drive data[k], k = 1..7; after bit 7: beat counter 0 -> IDLE with done, else -> BEAT_WAIT.
REQ-027 Bit and beat counters SHALL not wrap: bit counter max 11, beat counter 12 bits, decrement only when > 0.
REQ-028 tx_address/tx_data SHALL be 0 whenever not in REQ, ADDR_SHIFT, BEAT_REQ, BEAT_SHIFT.
REQ-029 req_valid asserted while busy SHALL be ignored (req_ready = 0); no queuing.
REQ-030 Input changes after acceptance SHALL not affect the transaction in flight.
REQ-031 slave_ready deasserting during ADDR_SHIFT/BEAT_SHIFT SHALL not stall serialization.

Reset
REQ-032 Reset SHALL force IDLE; master_valid, tx_address, tx_data, read_en, write_en, busy, done, wdata_ready = 0; burst = 0; counters and shift registers = 0; req_ready = 1 after release.
REQ-033 Reset mid-transaction SHALL abort immediately with no done pulse; next request starts cleanly from REQ.

Verification
REQ-034 Read, address 12'hA5C, burst 0, slave_ready = 1 -> master_valid one cycle, tx_address = 0,0,1,1,1,0,1,0,0,1,0,1 over 12 cycles, read_en = 1, done 12 cycles after handshake.
REQ-035 Write, address 12'h001, data 8'h96, slave_ready low 3 cycles -> master_valid held 4 cycles, tx_data = 0,1,1,0,1,0,0,1 from handshake, then 0.
REQ-036 Write burst 13'b0000000000101 (2 extra beats), wdata 8'h11 then 8'h22 -> three master_valid handshakes, data 96/11/22 serialized, one done pulse.
REQ-037 Read burst 13'd7 -> single address transfer, no wdata_ready, done after 12 cycles.
REQ-038 Reset asserted at ADDR_SHIFT bit 5 -> all outputs 0 in same cycle, no done; new request after release serializes correctly.
REQ-039 req_valid pulsed while busy -> ignored, no second transaction.
